br_resolve: RTL

BR_RESOLVE -- requirements
Module: br_resolve

---
 rtl/br_resolve_pkg.sv | 35 +++
 rtl/br_age_sel.sv | 30 +++
 rtl/br_resolve.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/br_resolve_pkg.sv
// Shared branch-resolution types: the resolved-lane record and the flush FSM states.
// The macro defaults below apply only if stddef.vh has not already defined them.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef RobDepth
`define RobDepth 16
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

package br_resolve_pkg;

    localparam int ADDR_W = `AddrWidth;
    localparam int ROB_W  = $clog2(`RobDepth);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } br_state_e;

    // Record widths follow the package defaults; instances must keep ADDR/ROB_DEPTH matching.
    typedef struct packed {
        logic              valid;
        logic              jump;
        logic              miss;
        logic [ROB_W-1:0]  age;
        logic [ADDR_W-1:0] addr;
    } br_lane_t;

endpackage

// File: rtl/br_age_sel.sv
// Picks the oldest mispredicting lane; ties go to the lowest lane index.
// Output record is all-zero when no lane mispredicts.
module br_age_sel
    import br_resolve_pkg::*;
#(
    parameter int LANES = 2,
    parameter int ROB   = ROB_W
) (
    input  br_lane_t lanes_i [LANES],
    output br_lane_t sel_o
);

    logic           found;
    logic [ROB-1:0] best_age;

    always_comb begin
        sel_o    = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < LANES; i++) begin
            // Strict compare keeps the earlier lane on equal age.
            if (lanes_i[i].valid && lanes_i[i].miss && (!found || (lanes_i[i].age < best_age))) begin
                sel_o    = lanes_i[i];
                found    = 1'b1;
                best_age = lanes_i[i].age;
            end
        end
    end

endmodule

// File: rtl/br_resolve.sv
// Branch/jump resolution: detects mispredicts, holds the oldest pending flush until
// acknowledged, emits registered predictor updates and keeps branch/miss statistics.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int ADDR      = `AddrWidth,
    parameter int ROB_DEPTH = `RobDepth,
    parameter int LANES     = 2,
    parameter int CNT       = 32,
    localparam int ROB      = $clog2(ROB_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [LANES-1:0]           lane_valid,
    input  logic [LANES-1:0]           lane_jump,
    input  logic [LANES-1:0][ADDR-1:0] lane_res,
    input  logic [LANES-1:0][ADDR-1:0] lane_pc,
    input  logic [LANES-1:0][ADDR-1:0] lane_br_target,
    input  logic [LANES-1:0]           lane_pred_taken,
    input  logic [LANES-1:0][ADDR-1:0] lane_pred_addr,
    input  logic [LANES-1:0][ROB-1:0]  lane_rob_id,
    input  logic [ROB-1:0]             rob_head,
    output logic                       flush_valid,
    output logic [ROB-1:0]             flush_rob_id,
    output logic [ADDR-1:0]            flush_addr,
    input  logic                       flush_ack,
    output logic [LANES-1:0]           upd_valid,
    output logic [LANES-1:0][ADDR-1:0] upd_pc,
    output logic [LANES-1:0][ADDR-1:0] upd_target,
    output logic [LANES-1:0]           upd_taken,
    output logic [CNT-1:0]             br_cnt,
    output logic [CNT-1:0]             miss_cnt,
    output br_state_e                  dbg_state
);

    // Flush handshake: flush_valid stays high until a cycle with flush_ack=1;
    // the pending id/addr may only be replaced by a strictly older mispredict.
    br_state_e                  state_q, state_d;
    logic [ROB-1:0]             flush_id_q, flush_id_d;
    logic [ADDR-1:0]            flush_addr_q, flush_addr_d;
    logic [LANES-1:0]           upd_valid_q, upd_valid_d;
    logic [LANES-1:0][ADDR-1:0] upd_pc_q, upd_pc_d;
    logic [LANES-1:0][ADDR-1:0] upd_target_q, upd_target_d;
    logic [LANES-1:0]           upd_taken_q, upd_taken_d;
    logic [CNT-1:0]             br_cnt_q, br_cnt_d;
    logic [CNT-1:0]             miss_cnt_q, miss_cnt_d;
    logic [CNT-1:0]             br_inc, miss_inc;

    br_lane_t       lane_rec [LANES];
    br_lane_t       sel_rec;
    logic           cand;
    logic           cand_older;
    logic [ROB-1:0] pend_age;
    logic           unused_sel_jump;

    always_comb begin
        br_inc   = '0;
        miss_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_rec[i].valid = lane_valid[i];
            lane_rec[i].jump  = lane_jump[i];
            lane_rec[i].miss  = lane_valid[i] &
                                (lane_jump[i] ? (lane_res[i] != lane_pred_addr[i])
                                              : (lane_res[i][0] != lane_pred_taken[i]));
            // Modular subtraction makes the age immune to ROB id wrap-around.
            lane_rec[i].age   = lane_rob_id[i] - rob_head;
            if (lane_jump[i])
                lane_rec[i].addr = lane_res[i];
            else if (lane_res[i][0])
                lane_rec[i].addr = lane_br_target[i];
            else
                lane_rec[i].addr = lane_pc[i] + ADDR'(4);
            br_inc   = br_inc + CNT'(lane_rec[i].valid);
            miss_inc = miss_inc + CNT'(lane_rec[i].miss);
        end
    end

    br_age_sel #(
        .LANES (LANES),
        .ROB   (ROB)
    ) u_age_sel (
        .lanes_i (lane_rec),
        .sel_o   (sel_rec)
    );

    assign unused_sel_jump = sel_rec.jump;
    assign cand       = sel_rec.valid & sel_rec.miss;
    assign pend_age   = flush_id_q - rob_head;
    assign cand_older = cand && (sel_rec.age < pend_age);

    always_comb begin
        state_d      = state_q;
        flush_id_d   = flush_id_q;
        flush_addr_d = flush_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (cand) begin
                    state_d      = ST_HOLD;
                    flush_id_d   = sel_rec.age + rob_head;
                    flush_addr_d = sel_rec.addr;
                end
            end
            ST_HOLD: begin
                if (cand_older) begin
                    flush_id_d   = sel_rec.age + rob_head;
                    flush_addr_d = sel_rec.addr;
                end else if (flush_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        upd_valid_d = lane_valid;
        for (int i = 0; i < LANES; i++) begin
            upd_pc_d[i]     = lane_valid[i] ? lane_pc[i] : '0;
            upd_taken_d[i]  = lane_valid[i] & (lane_rec[i].jump | lane_res[i][0]);
            upd_target_d[i] = !lane_valid[i] ? '0 :
                              (lane_rec[i].jump ? lane_res[i] : lane_br_target[i]);
        end
        br_cnt_d   = br_cnt_q + br_inc;
        miss_cnt_d = miss_cnt_q + miss_inc;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            flush_id_q   <= '0;
            flush_addr_q <= '0;
            upd_valid_q  <= '0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            upd_taken_q  <= '0;
            br_cnt_q     <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_id_q   <= flush_id_d;
            flush_addr_q <= flush_addr_d;
            upd_valid_q  <= upd_valid_d;
            upd_pc_q     <= upd_pc_d;
            upd_target_q <= upd_target_d;
            upd_taken_q  <= upd_taken_d;
            br_cnt_q     <= br_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign flush_valid  = (state_q == ST_HOLD) ? `Enable : `Disable;
    assign flush_rob_id = flush_id_q;
    assign flush_addr   = flush_addr_q;
    assign upd_valid    = upd_valid_q;
    assign upd_pc       = upd_pc_q;
    assign upd_target   = upd_target_q;
    assign upd_taken    = upd_taken_q;
    assign br_cnt       = br_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign dbg_state    = state_q;

endmodule
